// File: rtl/card_pile_pkg.sv
// Shared definitions for the card-storage request/done handshake.
// Op encodings, pile ids, capacity and out1 field layout.
package card_pile_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_DRAW  = 2'd1,
    OP_FILL  = 2'd2,
    OP_COUNT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    PILE_DECK   = 2'd0,
    PILE_PLAYER = 2'd1,
    PILE_COM    = 2'd2,
    PILE_BAD    = 2'd3
  } pile_e;

  localparam int MAX_CARDS_DEF = 52;
  localparam int MEM_WORDS     = 192;

  localparam int OUT_ERR_BIT  = 15;
  localparam int OUT_CNT_LSB  = 8;
  localparam int OUT_CARD_LSB = 0;

  function automatic logic [15:0] pack_out(
    input logic       err,
    input logic [5:0] cnt,
    input logic [5:0] card
  );
    logic [15:0] r;
    r = '0;
    r[OUT_ERR_BIT] = err;
    r[OUT_CNT_LSB +: 6] = cnt;
    r[OUT_CARD_LSB +: 6] = card;
    return r;
  endfunction

endpackage

// File: rtl/card_pile_server_mem.sv
// 192 x 6 single-port RAM, synchronous read with one cycle latency.
// A write cycle leaves the read register untouched.
module card_mem
  import card_pile_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [5:0] wdata,
  output logic [5:0] rdata
);

  localparam logic [7:0] LAST_ADDR = 8'(MEM_WORDS - 1);

  logic [5:0] mem_q [0:MEM_WORDS-1];

  always_ff @(posedge clock) begin
    if (we) begin
      if (addr <= LAST_ADDR) mem_q[addr] <= wdata;
    end else begin
      rdata <= (addr <= LAST_ADDR) ? mem_q[addr] : 6'd0;
    end
  end

endmodule

// File: rtl/card_pile_server.sv
// Card pile server: push, indexed draw-and-remove, fill and count
// on three piles held in one shared RAM.
module card_pile_server
  import card_pile_pkg::*;
#(
  parameter int MAX_CARDS = MAX_CARDS_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic [1:0]  select_op,
  input  logic [9:0]  arg1,
  input  logic [9:0]  arg2,
  output logic        finished_op,
  output logic [15:0] out1
);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_MOD, S_RD, S_CAP, S_SH_RD,
    S_SH_WR, S_PUSH_WR, S_FILL_WR, S_DONE, S_GAP
  } state_e;

  localparam logic [5:0] MAXC     = 6'(MAX_CARDS);
  localparam logic [5:0] LAST_IDX = 6'(MAX_CARDS - 1);

  state_e      state_q;
  op_e         op_q;
  pile_e       pile_q;
  logic [9:0]  arg2_q;
  logic [9:0]  idx_q;
  logic [5:0]  card_q;
  logic [1:0]  suit_q;
  logic [3:0]  rank_q;
  logic [5:0]  cnt_q [0:3];
  logic        finished_q;
  logic [15:0] out1_q;

  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [5:0]  mem_wdata;
  logic [5:0]  mem_rdata;

  logic [5:0]  cur_cnt;
  logic [9:0]  cnt10;
  logic [9:0]  idx0;
  logic [9:0]  idx_sub;
  logic [5:0]  pos;
  logic        more_cap;
  logic        more_wr;
  logic        req_err;
  logic        unused_arg1;

  assign unused_arg1 = ^arg1[9:2];

  // Id 3 never gets written, so its slot always reads 0.
  assign cur_cnt  = cnt_q[pile_q];
  assign cnt10    = {4'd0, cur_cnt};
  assign idx0     = (arg2_q == 10'd0) ? 10'd0 : arg2_q - 10'd1;
  assign idx_sub  = idx_q - cnt10;
  assign pos      = idx_q[5:0];
  assign more_cap = ({1'b0, pos} + 7'd1) < {1'b0, cur_cnt};
  assign more_wr  = ({1'b0, pos} + 7'd2) < {1'b0, cur_cnt};
  assign req_err  = (pile_q == PILE_BAD)
                 || (op_q == OP_PUSH && cur_cnt == MAXC)
                 || (op_q == OP_DRAW && cur_cnt == 6'd0);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {pile_q, pos};
    mem_wdata = '0;
    unique case (state_q)
      S_SH_RD: mem_addr = {pile_q, pos + 6'd1};
      S_SH_WR: begin
        mem_we    = 1'b1;
        mem_wdata = mem_rdata;
      end
      S_PUSH_WR: begin
        mem_we    = 1'b1;
        mem_addr  = {pile_q, cur_cnt};
        mem_wdata = arg2_q[5:0];
      end
      S_FILL_WR: begin
        mem_we    = 1'b1;
        mem_wdata = {suit_q, rank_q};
      end
      default: ;
    endcase
  end

  card_mem u_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      op_q       <= OP_PUSH;
      pile_q     <= PILE_DECK;
      arg2_q     <= '0;
      idx_q      <= '0;
      card_q     <= '0;
      suit_q     <= '0;
      rank_q     <= '0;
      finished_q <= 1'b0;
      out1_q     <= '0;
      for (int p = 0; p < 4; p++) cnt_q[p] <= '0;
    end else begin
      finished_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (enable) begin
          op_q    <= op_e'(select_op);
          pile_q  <= pile_e'(arg1[1:0]);
          arg2_q  <= arg2;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          idx_q <= idx0;
          if (req_err) begin
            out1_q     <= pack_out(1'b1, cur_cnt, 6'd0);
            finished_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            unique case (op_q)
              OP_PUSH: state_q <= S_PUSH_WR;
              OP_DRAW: state_q <= (idx0 < cnt10) ? S_RD : S_MOD;
              OP_FILL: begin
                idx_q   <= '0;
                suit_q  <= '0;
                rank_q  <= 4'd1;
                state_q <= S_FILL_WR;
              end
              OP_COUNT: begin
                out1_q     <= pack_out(1'b0, cur_cnt, 6'd0);
                finished_q <= 1'b1;
                state_q    <= S_DONE;
              end
              default: state_q <= S_DONE;
            endcase
          end
        end
        S_MOD: begin
          idx_q <= idx_sub;
          if (idx_sub < cnt10) state_q <= S_RD;
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          card_q <= mem_rdata;
          if (more_cap) begin
            state_q <= S_SH_RD;
          end else begin
            cnt_q[pile_q] <= cur_cnt - 6'd1;
            out1_q        <= pack_out(1'b0, cur_cnt - 6'd1, mem_rdata);
            finished_q    <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_SH_RD: state_q <= S_SH_WR;
        S_SH_WR: begin
          idx_q <= idx_q + 10'd1;
          if (more_wr) begin
            state_q <= S_SH_RD;
          end else begin
            cnt_q[pile_q] <= cur_cnt - 6'd1;
            out1_q        <= pack_out(1'b0, cur_cnt - 6'd1, card_q);
            finished_q    <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_PUSH_WR: begin
          cnt_q[pile_q] <= cur_cnt + 6'd1;
          out1_q        <= pack_out(1'b0, cur_cnt + 6'd1, arg2_q[5:0]);
          finished_q    <= 1'b1;
          state_q       <= S_DONE;
        end
        S_FILL_WR: begin
          idx_q <= idx_q + 10'd1;
          if (rank_q == 4'd13) begin
            rank_q <= 4'd1;
            suit_q <= suit_q + 2'd1;
          end else begin
            rank_q <= rank_q + 4'd1;
          end
          if (pos == LAST_IDX) begin
            cnt_q[pile_q] <= MAXC;
            out1_q        <= pack_out(1'b0, MAXC, 6'd0);
            finished_q    <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_DONE: state_q <= S_GAP;
        S_GAP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign finished_op = finished_q;
  assign out1        = out1_q;

endmodule

// File: tb/tb_card_pile_server.sv
// Scoreboard bench for card_pile_server: directed requests queue
// their expected out1 and pulse cycle; a monitor checks each pulse.
module tb_card_pile_server;
  import card_pile_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  select_op = 2'd0;
  logic [9:0]  arg1 = '0;
  logic [9:0]  arg2 = '0;
  logic        finished_op;
  logic [15:0] out1;

  card_pile_server #(.MAX_CARDS(52)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .select_op   (select_op),
    .arg1        (arg1),
    .arg2        (arg2),
    .finished_op (finished_op),
    .out1        (out1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] out;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clock) begin
    exp_t e;
    if (resetn && finished_op) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: out1=%h at cyc %0d, required no pulse",
                 out1, cyc);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (out1 !== e.out) begin
          errors++;
          $display("FAIL %s_out1: got %h, required %h", e.name, out1, e.out);
        end
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL %s_timing: pulse at cyc %0d, required %0d",
                   e.name, cyc, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic wait_pulse(input string nm, input int lim);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clock);
      if (finished_op) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no pulse, required one within %0d cycles",
               nm, lim);
    end
  endtask

  task automatic send(input string nm, input logic [1:0] op,
                      input logic [9:0] a1, input logic [9:0] a2,
                      input logic [15:0] exp, input int lat);
    @(negedge clock);
    enable = 1'b1;
    select_op = op;
    arg1 = a1;
    arg2 = a2;
    @(posedge clock);
    #1;
    sb.push_back('{out: exp, cyc: cyc + lat - 1, name: nm});
    enable = 1'b0;
    wait_pulse(nm, lat + 20);
    @(posedge clock);
    @(posedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int a1c;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_pulse", {15'd0, finished_op}, 16'h0000);
    chk("rst_out1", out1, 16'h0000);
    resetn = 1'b1;

    send("count0", OP_COUNT, 10'd0, 10'd0, 16'h0000, 2);
    send("fill0", OP_FILL, 10'd0, 10'd0, 16'h3400, 54);
    send("draw_a1", OP_DRAW, 10'd0, 10'd1, 16'h3301, 106);
    send("draw_a13", OP_DRAW, 10'd0, 10'd13, 16'h3211, 80);
    send("refill0", OP_FILL, 10'd0, 10'd0, 16'h3400, 54);
    send("draw_a105", OP_DRAW, 10'd0, 10'd105, 16'h3301, 108);

    send("push1_a", OP_PUSH, 10'd1, 10'h02D, 16'h012D, 3);
    send("push1_b", OP_PUSH, 10'd1, 10'h02D, 16'h022D, 3);
    send("push1_c", OP_PUSH, 10'd1, 10'h02D, 16'h032D, 3);
    send("draw1_a2", OP_DRAW, 10'd1, 10'd2, 16'h022D, 6);
    send("count1", OP_COUNT, 10'd1, 10'd0, 16'h0200, 2);

    send("draw_empty2", OP_DRAW, 10'd2, 10'd1, 16'h8000, 2);
    send("push0_last", OP_PUSH, 10'd0, 10'h00D, 16'h340D, 3);
    send("push0_full", OP_PUSH, 10'd0, 10'h00E, 16'hB400, 2);
    send("count0_full", OP_COUNT, 10'd0, 10'd0, 16'h3400, 2);
    send("bad_id_count", OP_COUNT, 10'd3, 10'd0, 16'h8000, 2);
    send("bad_id_draw", OP_DRAW, 10'h3FF, 10'd1, 16'h8000, 2);
    send("hi_bits_id1", OP_COUNT, 10'h101, 10'd0, 16'h0200, 2);
    send("count0_after", OP_COUNT, 10'd0, 10'd0, 16'h3400, 2);

    send("draw_a0", OP_DRAW, 10'd0, 10'd0, 16'h3302, 106);
    send("draw_a60", OP_DRAW, 10'd0, 10'd60, 16'h320B, 89);

    // enable held high across DONE and GAP; args change in GAP
    @(negedge clock);
    enable = 1'b1;
    select_op = OP_COUNT;
    arg1 = 10'd1;
    arg2 = 10'd0;
    @(posedge clock);
    #1;
    a1c = cyc;
    sb.push_back('{out: 16'h0200, cyc: a1c + 1, name: "b2b_first"});
    wait_pulse("b2b_first", 22);
    @(negedge clock);
    select_op = OP_PUSH;
    arg1 = 10'd2;
    arg2 = 10'h005;
    sb.push_back('{out: 16'h0105, cyc: a1c + 6, name: "b2b_second"});
    @(posedge clock);
    @(posedge clock);
    #1;
    enable = 1'b0;
    wait_pulse("b2b_second", 23);
    @(posedge clock);
    @(posedge clock);
    send("count2_once", OP_COUNT, 10'd2, 10'd0, 16'h0100, 2);

    // reset in the middle of a long draw
    @(negedge clock);
    enable = 1'b1;
    select_op = OP_DRAW;
    arg1 = 10'd0;
    arg2 = 10'd1;
    @(posedge clock);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    chk("midrst_pulse", {15'd0, finished_op}, 16'h0000);
    chk("midrst_out1", out1, 16'h0000);
    resetn = 1'b1;
    repeat (150) @(negedge clock);
    send("rst_count0", OP_COUNT, 10'd0, 10'd0, 16'h0000, 2);
    send("rst_count1", OP_COUNT, 10'd1, 10'd0, 16'h0000, 2);
    send("rst_count2", OP_COUNT, 10'd2, 10'd0, 16'h0000, 2);

    chk("sb_empty", 16'(sb.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
